fft_frame_reader: RTL and testbench

Consumer for the ping-pong sample buffer's read port. It waits until a complete buffer is available and pulls exactly DEPTH samples through the valid/ready read handshake. It re-emits them as a framed stream with first/last markers for the downstream FFT core and absorbs output backpressure with a one-entry output register. It sits between the ping-pong buffer read side and the FFT input.

---
 rtl/fft_frame_reader.sv | 166 ++++++++++++++++
 tb/tb_fft_frame_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_reader.sv
// Purpose : pulls one complete DEPTH-sample frame from the ping-pong buffer read
//           port and re-emits it as a framed stream (first/last) toward the FFT.
// Latency : one cycle from read handshake to m_valid_o; frame = DEPTH + 1 cycles.
// Backpressure: one-entry output register; read_ready_o follows !m_valid_o | m_ready_i.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   enable_i                  permits starting new frames (a running frame always completes)
//   buffer_ready_i            a full buffer is readable (sampled only in IDLE)
//   read_data_i/_valid_i/read_ready_o   buffer read handshake
//   m_data_o/_valid_o/m_ready_i, m_first_o, m_last_o   framed output stream
//   busy_o, sample_idx_o      status: not idle, index of next sample to read
//   frame_done_o              one-cycle pulse after the last sample leaves the output
//   frame_count_o, stall_count_o   saturating statistics
//
// Build option: define FFT_FRAME_READER_STATS_EN to build the statistics counters;
// without it both counter ports are constant zero and no counter flops exist.
module fft_frame_reader #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  buffer_ready_i,
    input  logic [WIDTH-1:0]      read_data_i,
    input  logic                  read_valid_i,
    output logic                  read_ready_o,
    output logic [WIDTH-1:0]      m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_first_o,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] sample_idx_o,
    output logic                  frame_done_o,
    output logic [15:0]           frame_count_o,
    output logic [15:0]           stall_count_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  rd_rdy;
    logic                  out_hs;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;
        done_d  = 1'b0;
        rd_rdy  = 1'b0;
        out_hs  = valid_q & m_ready_i;

        // The output slot empties on a downstream handshake; a load below overrides this.
        if (out_hs) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable_i && buffer_ready_i) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                // Combinational from m_ready_i so a full-rate stream never bubbles.
                rd_rdy = !valid_q || m_ready_i;
                if (read_valid_i && rd_rdy) begin
                    data_d  = read_data_i;
                    valid_d = 1'b1;
                    first_d = (idx_q == '0);
                    last_d  = (idx_q == LAST_IDX);
                    // DEPTH is a power of two, so the natural wrap returns idx to 0.
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_hs && last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign read_ready_o = rd_rdy;
    assign m_data_o     = data_q;
    assign m_valid_o    = valid_q;
    assign m_first_o    = first_q;
    assign m_last_o     = last_q;
    assign busy_o       = (state_q != IDLE);
    assign sample_idx_o = idx_q;
    assign frame_done_o = done_q;

`ifdef FFT_FRAME_READER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] stall_cnt_q;

    // Frame count steps on the same edge that raises frame_done_o, so the
    // count and the pulse become visible together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (done_d && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (valid_q && !m_ready_i && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign frame_count_o = frame_cnt_q;
    assign stall_count_o = stall_cnt_q;
`else
    assign frame_count_o = '0;
    assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_fft_frame_reader.sv
module tb_fft_frame_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic             clk_i;
    logic             rst_ni;
    logic             enable_i;
    logic             buffer_ready_i;
    logic [WIDTH-1:0] read_data_i;
    logic             read_valid_i;
    logic             read_ready_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_valid_o;
    logic             m_ready_i;
    logic             m_first_o;
    logic             m_last_o;
    logic             busy_o;
    logic [AW-1:0]    sample_idx_o;
    logic             frame_done_o;
    logic [15:0]      frame_count_o;
    logic [15:0]      stall_count_o;

    fft_frame_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .buffer_ready_i (buffer_ready_i),
        .read_data_i    (read_data_i),
        .read_valid_i   (read_valid_i),
        .read_ready_o   (read_ready_o),
        .m_data_o       (m_data_o),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_first_o      (m_first_o),
        .m_last_o       (m_last_o),
        .busy_o         (busy_o),
        .sample_idx_o   (sample_idx_o),
        .frame_done_o   (frame_done_o),
        .frame_count_o  (frame_count_o),
        .stall_count_o  (stall_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int exp_stalls = 0;

    typedef struct {
        logic [WIDTH-1:0] base;
        bit               bp;
        int               gap_at;
        int               gap_len;
        int               en_drop_at;
        logic [WIDTH-1:0] exp_first;
        logic [WIDTH-1:0] exp_last;
        int               exp_samples;
        int               exp_frames;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input int exp_frames);
`ifdef FFT_FRAME_READER_STATS_EN
        chk({tag, " frame_count"}, 64'(frame_count_o), 64'(exp_frames));
        chk({tag, " stall_count"}, 64'(stall_count_o), 64'(exp_stalls));
`else
        chk({tag, " frame_count"}, 64'(frame_count_o), 64'(0 * exp_frames));
        chk({tag, " stall_count"}, 64'(stall_count_o), 64'(0 * exp_stalls));
`endif
    endtask

    // Acts as the buffer read side plus the FFT sink; every call starts and ends
    // just after a falling edge.
    task automatic run_frame(input vec_t v, input int rst_at, input string tag);
        int               src = 0;
        int               outn = 0;
        int               cyc = 0;
        int               first_rr = -1;
        int               gap_rem = v.gap_len;
        bit               done = 1'b0;
        bit               aborted = 1'b0;
        logic [WIDTH-1:0] first_dat = '0;
        logic [WIDTH-1:0] last_dat = '0;
        enable_i       = 1'b1;
        buffer_ready_i = 1'b1;
        while (!done && !aborted && cyc < 4000) begin
            @(negedge clk_i);
            cyc++;
            if (frame_done_o) begin
                done = 1'b1;
            end else if (src == rst_at) begin
                rst_ni = 1'b0;
                #1;
                chk({tag, " rst m_valid"}, 64'(m_valid_o), 64'(0));
                chk({tag, " rst sample_idx"}, 64'(sample_idx_o), 64'(0));
                chk({tag, " rst busy"}, 64'(busy_o), 64'(0));
                chk({tag, " rst read_ready"}, 64'(read_ready_o), 64'(0));
                exp_stalls = 0;
                chk_stats({tag, " rst"}, 0);
                aborted = 1'b1;
            end else begin
                m_ready_i = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (v.en_drop_at >= 0 && src >= v.en_drop_at) enable_i = 1'b0;
                if (src == DEPTH) buffer_ready_i = (v.en_drop_at >= 0);
                if (src == v.gap_at && gap_rem > 0) begin
                    read_valid_i = 1'b0;
                    gap_rem--;
                    chk({tag, " gap sample_idx"}, 64'(sample_idx_o), 64'(v.gap_at));
                    chk({tag, " gap busy"}, 64'(busy_o), 64'(1));
                end else begin
                    read_valid_i = (src < DEPTH);
                    read_data_i  = v.base + WIDTH'(src);
                end
                #1;
                if (read_ready_o && first_rr < 0) first_rr = cyc;
                if (m_valid_o && !m_ready_i) exp_stalls++;
                if (m_valid_o && m_ready_i) begin
                    chk({tag, " data"}, 64'(m_data_o), 64'(v.base + WIDTH'(outn)));
                    chk({tag, " first/last"}, 64'({m_first_o, m_last_o}),
                        64'({outn == 0, outn == DEPTH - 1}));
                    if (outn == 0) first_dat = m_data_o;
                    if (outn == DEPTH - 1) last_dat = m_data_o;
                    outn++;
                end
                if (read_valid_i && read_ready_o) src++;
            end
        end
        read_valid_i = 1'b0;
        if (aborted) begin
            buffer_ready_i = 1'b0;
            m_ready_i      = 1'b1;
            repeat (2) @(negedge clk_i);
            rst_ni = 1'b1;
            #1;
        end else begin
            chk({tag, " frame_done seen (timeout)"}, 64'(done), 64'(1));
            chk({tag, " samples out"}, 64'(outn), 64'(v.exp_samples));
            chk({tag, " samples read"}, 64'(src), 64'(DEPTH));
            chk({tag, " start latency"}, 64'(first_rr), 64'(1));
            chk({tag, " first sample"}, 64'(first_dat), 64'(v.exp_first));
            chk({tag, " last sample"}, 64'(last_dat), 64'(v.exp_last));
            m_ready_i = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk_i);
                #1;
                chk({tag, " post frame_done"}, 64'(frame_done_o), 64'(0));
                chk({tag, " post busy"}, 64'(busy_o), 64'(0));
                chk({tag, " post m_valid"}, 64'(m_valid_o), 64'(0));
            end
            chk_stats(tag, v.exp_frames);
            buffer_ready_i = 1'b0;
            enable_i       = 1'b1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        //            base      bp  gap  len  en   first     last      n      frames
        vecs[0] = '{32'h3000, 1'b0,  -1, 0,  -1, 32'h3000, 32'h30FF, DEPTH, 1};
        vecs[1] = '{32'h3800, 1'b1,  -1, 0,  -1, 32'h3800, 32'h38FF, DEPTH, 2};
        vecs[2] = '{32'h3C00, 1'b0, 100, 3,  -1, 32'h3C00, 32'h3CFF, DEPTH, 3};
        vecs[3] = '{32'h4000, 1'b0,  -1, 0,  -1, 32'h4000, 32'h40FF, DEPTH, 4};
        vecs[4] = '{32'h5000, 1'b0,  -1, 0,  -1, 32'h5000, 32'h50FF, DEPTH, 5};
        vecs[5] = '{32'h7000, 1'b0,  -1, 0,  10, 32'h7000, 32'h70FF, DEPTH, 6};

        rst_ni         = 1'b0;
        enable_i       = 1'b1;
        buffer_ready_i = 1'b0;
        read_valid_i   = 1'b0;
        read_data_i    = '0;
        m_ready_i      = 1'b1;
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("reset read_ready", 64'(read_ready_o), 64'(0));
        chk("reset m_valid", 64'(m_valid_o), 64'(0));
        chk("reset m_data", 64'(m_data_o), 64'(0));
        chk("reset m_first", 64'(m_first_o), 64'(0));
        chk("reset m_last", 64'(m_last_o), 64'(0));
        chk("reset busy", 64'(busy_o), 64'(0));
        chk("reset sample_idx", 64'(sample_idx_o), 64'(0));
        chk("reset frame_done", 64'(frame_done_o), 64'(0));
        chk_stats("reset", 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            #1;
            chk("idle no buffer busy", 64'(busy_o), 64'(0));
            chk("idle no buffer read_ready", 64'(read_ready_o), 64'(0));
        end

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], -1, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a frame, then a clean frame to prove recovery.
        rv = '{32'h2000, 1'b0, -1, 0, -1, 32'h2000, 32'h20FF, DEPTH, 0};
        run_frame(rv, 50, "midreset");
        rv = '{32'h6000, 1'b0, -1, 0, -1, 32'h6000, 32'h60FF, DEPTH, 1};
        run_frame(rv, -1, "recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
